// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared types and helpers for the pipelined CLA add/sub unit
package cla_pkg;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } op_e;

   function automatic int calc_ng(input int width, input int group);
      return width / group;
   endfunction

endpackage

// File: rtl/cla_group.sv
// rtl/cla_group.sv - combinational GROUP-bit carry-lookahead adder slice
module cla_group #(
   parameter int GROUP = 4
) (
   input  logic [GROUP-1:0] a,
   input  logic [GROUP-1:0] b,
   input  logic             cin,
   output logic [GROUP-1:0] sum,
   output logic             cout
);

   logic [GROUP-1:0] g;
   logic [GROUP-1:0] p;
   logic [GROUP:0]   c;
   logic             term;
   logic             acc;

   assign g = a & b;
   assign p = a ^ b;

   // Every carry is a flat sum-of-products of g/p/cin, never a ripple of c[i].
   always_comb begin
      c    = '0;
      term = 1'b0;
      acc  = 1'b0;
      c[0] = cin;
      for (int i = 0; i < GROUP; i++) begin
         term = cin;
         for (int j = 0; j <= i; j++) term = term & p[j];
         acc = term;
         for (int j = 0; j <= i; j++) begin
            term = g[j];
            for (int m = j + 1; m <= i; m++) term = term & p[m];
            acc = acc | term;
         end
         c[i+1] = acc;
      end
   end

   assign sum  = p ^ c[GROUP-1:0];
   assign cout = c[GROUP];

endmodule

// File: rtl/cla_addsub_pipe.sv
// rtl/cla_addsub_pipe.sv - pipelined CLA add/subtract unit, one register stage per GROUP-bit slice
module cla_addsub_pipe
   import cla_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int GROUP = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int NG = calc_ng(WIDTH, GROUP);

   if (WIDTH % GROUP != 0) begin : g_bad_cfg
      $error("cla_addsub_pipe: WIDTH must be a multiple of GROUP");
   end

   logic             adv;
   logic             is_sub;
   logic [WIDTH-1:0] in_bx;
   logic             in_c0;
   logic             ovf_q;
   logic             zero_q;

   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   // Subtraction is folded into the operands once at the input, so later stages only add.
   assign is_sub = (op_e'(op) == OP_SUB);
   assign in_bx  = is_sub ? ~b : b;
   assign in_c0  = is_sub ? !cin : cin;

   for (genvar k = 0; k < NG; k++) begin : g_stage
      localparam int RW = WIDTH - k * GROUP;  // operand bits not yet consumed at this stage's input

      logic [RW-1:0]          a_k;
      logic [RW-1:0]          b_k;
      logic                   c_k;
      logic                   v_k;
      logic [GROUP-1:0]       g_sum;
      logic                   g_cout;
      logic [(k+1)*GROUP-1:0] s_d;
      logic [(k+1)*GROUP-1:0] s_q;
      logic                   c_q;
      logic                   v_q;

      if (k == 0) begin : g_src
         assign a_k = a;
         assign b_k = in_bx;
         assign c_k = in_c0;
         assign v_k = in_valid;
         assign s_d = g_sum;
      end else begin : g_src
         assign a_k = g_stage[k-1].g_fwd.a_q;
         assign b_k = g_stage[k-1].g_fwd.b_q;
         assign c_k = g_stage[k-1].c_q;
         assign v_k = g_stage[k-1].v_q;
         assign s_d = {g_sum, g_stage[k-1].s_q};
      end

      cla_group #(
         .GROUP(GROUP)
      ) u_grp (
         .a   (a_k[GROUP-1:0]),
         .b   (b_k[GROUP-1:0]),
         .cin (c_k),
         .sum (g_sum),
         .cout(g_cout)
      );

      always_ff @(posedge clk) begin
         if (rst) begin
            v_q <= 1'b0;
            s_q <= '0;
            c_q <= 1'b0;
         end else if (adv) begin
            v_q <= v_k;
            if (v_k) begin
               s_q <= s_d;
               c_q <= g_cout;
            end
         end
      end

      if (k < NG - 1) begin : g_fwd
         logic [RW-GROUP-1:0] a_q;
         logic [RW-GROUP-1:0] b_q;

         always_ff @(posedge clk) begin
            if (rst) begin
               a_q <= '0;
               b_q <= '0;
            end else if (adv && v_k) begin
               a_q <= a_k[RW-1:GROUP];
               b_q <= b_k[RW-1:GROUP];
            end
         end
      end
   end

   // Flags are formed from the complete sum as it enters the last register.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_q  <= 1'b0;
         zero_q <= 1'b0;
      end else if (adv && g_stage[NG-1].v_k) begin
         zero_q <= (g_stage[NG-1].s_d == '0);
         ovf_q  <= (g_stage[NG-1].a_k[GROUP-1] == g_stage[NG-1].b_k[GROUP-1]) &&
                   (g_stage[NG-1].s_d[WIDTH-1] != g_stage[NG-1].a_k[GROUP-1]);
      end
   end

   assign out_valid = g_stage[NG-1].v_q;
   assign sum       = g_stage[NG-1].s_q;
   assign cout      = g_stage[NG-1].c_q;
   assign ovf       = ovf_q;
   assign zero      = zero_q;

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// tb/tb_cla_addsub_pipe.sv - self-checking bench for cla_addsub_pipe (8/4 and 5/5 configurations)
module tb_cla_addsub_pipe;

   typedef struct packed {
      logic [7:0] sum;
      logic       cout;
      logic       ovf;
      logic       zero;
   } res_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] a = '0;
   logic [7:0] b = '0;
   logic       cin = 1'b0;
   logic       op = 1'b0;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic [7:0] sum;
   logic       cout;
   logic       ovf;
   logic       zero;

   logic       in_valid5 = 1'b0;
   logic       in_ready5;
   logic [4:0] a5 = '0;
   logic [4:0] b5 = '0;
   logic       cin5 = 1'b0;
   logic       op5 = 1'b0;
   logic       out_valid5;
   logic       out_ready5 = 1'b1;
   logic [4:0] sum5;
   logic       cout5;
   logic       ovf5;
   logic       zero5;

   int   n_vec = 0;
   int   n_err = 0;
   res_t exp_q[$];
   res_t exp5_q[$];

   cla_addsub_pipe #(.WIDTH(8), .GROUP(4)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .op(op),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
   );

   cla_addsub_pipe #(.WIDTH(5), .GROUP(5)) u_dut5 (
      .clk(clk), .rst(rst), .in_valid(in_valid5), .in_ready(in_ready5),
      .a(a5), .b(b5), .cin(cin5), .op(op5),
      .out_valid(out_valid5), .out_ready(out_ready5),
      .sum(sum5), .cout(cout5), .ovf(ovf5), .zero(zero5)
   );

   always #5 clk = ~clk;

   // Reference: true signed/unsigned arithmetic at width w.
   function automatic res_t ref_calc(input int w, input logic [7:0] ia, input logic [7:0] ib,
                                     input logic icin, input logic iop);
      longint m, ua, ub, sa, sb, sv, c, r;
      res_t   res;
      m  = (longint'(1) << w) - 1;
      ua = longint'(ia) & m;
      ub = longint'(ib) & m;
      c  = icin ? 1 : 0;
      sa = ((ua >> (w - 1)) & 1) != 0 ? ua - (m + 1) : ua;
      sb = ((ub >> (w - 1)) & 1) != 0 ? ub - (m + 1) : ub;
      if (iop) begin
         sv       = sa - sb - c;
         res.cout = (ua >= ub + c);
      end else begin
         sv       = sa + sb + c;
         res.cout = (ua + ub + c) > m;
      end
      res.ovf  = (sv > (m >> 1)) || (sv < -((m + 1) >> 1));
      r        = sv & m;
      res.sum  = r[7:0];
      res.zero = (r == 0);
      return res;
   endfunction

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      #1;
      n_vec++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      n_vec++;
      if ({sum, cout, ovf, zero} !== 11'd0)
         begin n_err++; $display("FAIL reset_outputs got %h want 000", {sum, cout, ovf, zero}); end
      n_vec++;
      if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      n_vec++;
      if ({out_valid5, sum5, cout5, ovf5, zero5} !== 9'd0 || in_ready5 !== 1'b1)
         begin n_err++; $display("FAIL reset_w5 got %h/%b want 000/1", {out_valid5, sum5, cout5, ovf5, zero5}, in_ready5); end
      tick();
   endtask

   logic [7:0] ca [5] = '{8'hFF, 8'h7F, 8'h05, 8'h00, 8'h80};
   logic [7:0] cb [5] = '{8'h01, 8'h01, 8'h07, 8'h00, 8'h01};
   logic       cop[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
   res_t       cexp[5] = '{ '{8'h00, 1'b1, 1'b0, 1'b1}, '{8'h80, 1'b0, 1'b1, 1'b0},
                            '{8'hFE, 1'b0, 1'b0, 1'b0}, '{8'h00, 1'b1, 1'b0, 1'b1},
                            '{8'h7F, 1'b1, 1'b1, 1'b0} };

   task automatic test_corners();
      int   lat;
      res_t obs;
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         a = ca[i]; b = cb[i]; cin = 1'b0; op = cop[i]; in_valid = 1'b1;
         lat = 0;
         do begin
            tick();
            in_valid = 1'b0;
            a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); op = 1'($urandom);
            lat++;
         end while (!out_valid && lat < 8);
         n_vec++;
         if (lat !== 2) begin n_err++; $display("FAIL corner%0d_latency got %0d want 2", i, lat); end
         obs = {sum, cout, ovf, zero};
         n_vec++;
         if (obs !== cexp[i])
            begin n_err++; $display("FAIL corner%0d_result got %h want %h", i, obs, cexp[i]); end
         tick();
      end
   endtask

   task automatic test_stream();
      int   sent = 0, got = 0, first = -1, last = -1;
      res_t obs;
      exp_q.delete();
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
         a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); op = 1'($urandom);
         in_valid = (sent < 8);
         #1;
         n_vec++;
         if (in_ready !== 1'b1) begin n_err++; $display("FAIL stream_in_ready cyc %0d got %b want 1", cyc, in_ready); end
         if (out_valid) begin
            obs = {sum, cout, ovf, zero};
            n_vec++;
            if (exp_q.size() == 0) begin n_err++; $display("FAIL stream_extra got %h want none", obs); end
            else if (obs !== exp_q[0]) begin n_err++; $display("FAIL stream_result got %h want %h", obs, exp_q[0]); end
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            got++;
            if (first < 0) first = cyc;
            last = cyc;
         end
         if (in_valid && in_ready) begin exp_q.push_back(ref_calc(8, a, b, cin, op)); sent++; end
         tick();
      end
      in_valid = 1'b0;
      n_vec++;
      if (got !== 8 || last - first !== 7)
         begin n_err++; $display("FAIL stream_count got %0d results over %0d cycles want 8 over 8", got, last - first + 1); end
   endtask

   task automatic test_backpressure();
      int   sent = 0, got = 0;
      logic stalled = 1'b0;
      res_t held, obs;
      exp_q.delete();
      for (int cyc = 0; cyc < 60 && got < 10; cyc++) begin
         a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); op = 1'($urandom);
         in_valid  = (sent < 10);
         out_ready = !(cyc >= 3 && cyc < 8);
         #1;
         obs = {sum, cout, ovf, zero};
         if (cyc == 7) begin
            n_vec++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1)
               begin n_err++; $display("FAIL bp_full got in_ready=%b out_valid=%b want 0/1", in_ready, out_valid); end
         end
         if (stalled) begin
            n_vec++;
            if (out_valid !== 1'b1 || obs !== held)
               begin n_err++; $display("FAIL bp_hold got %b/%h want 1/%h", out_valid, obs, held); end
         end
         if (out_valid && out_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin n_err++; $display("FAIL bp_extra got %h want none", obs); end
            else if (obs !== exp_q[0]) begin n_err++; $display("FAIL bp_result got %h want %h", obs, exp_q[0]); end
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            got++;
         end
         stalled = out_valid && !out_ready;
         held    = obs;
         if (in_valid && in_ready) begin exp_q.push_back(ref_calc(8, a, b, cin, op)); sent++; end
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      n_vec++;
      if (got !== 10 || exp_q.size() !== 0)
         begin n_err++; $display("FAIL bp_count got %0d left %0d want 10 left 0", got, exp_q.size()); end
   endtask

   task automatic test_random_flow();
      int   sent = 0, got = 0;
      res_t obs;
      exp_q.delete();
      for (int cyc = 0; cyc < 300 && !(sent == 24 && got == 24); cyc++) begin
         a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); op = 1'($urandom);
         in_valid  = (sent < 24) && ($urandom_range(0, 2) != 0);
         out_ready = (sent >= 24) || ($urandom_range(0, 3) != 0);
         #1;
         if (out_valid && out_ready) begin
            obs = {sum, cout, ovf, zero};
            n_vec++;
            if (exp_q.size() == 0) begin n_err++; $display("FAIL flow_extra got %h want none", obs); end
            else if (obs !== exp_q[0]) begin n_err++; $display("FAIL flow_result got %h want %h", obs, exp_q[0]); end
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            got++;
         end
         if (in_valid && in_ready) begin exp_q.push_back(ref_calc(8, a, b, cin, op)); sent++; end
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      n_vec++;
      if (got !== 24 || sent !== 24)
         begin n_err++; $display("FAIL flow_count got %0d of %0d sent want 24 of 24", got, sent); end
   endtask

   task automatic test_mid_reset();
      int   lat;
      res_t obs, expv;
      out_ready = 1'b1;
      a = 8'h3C; b = 8'h21; cin = 1'b1; op = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         n_vec++;
         if (out_valid !== 1'b0 || {sum, cout, ovf, zero} !== 11'd0)
            begin n_err++; $display("FAIL midrst_cyc%0d got %b/%h want 0/000", i, out_valid, {sum, cout, ovf, zero}); end
         tick();
      end
      a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); op = 1'($urandom); in_valid = 1'b1;
      expv = ref_calc(8, a, b, cin, op);
      lat = 0;
      do begin
         tick();
         in_valid = 1'b0;
         lat++;
      end while (!out_valid && lat < 8);
      obs = {sum, cout, ovf, zero};
      n_vec++;
      if (lat !== 2 || obs !== expv)
         begin n_err++; $display("FAIL midrst_next got lat %0d %h want lat 2 %h", lat, obs, expv); end
      tick();
   endtask

   task automatic test_w5();
      int   lat, sent = 0, got = 0;
      res_t obs;
      out_ready5 = 1'b1;
      a5 = 5'd31; b5 = 5'd31; cin5 = 1'b0; op5 = 1'b0; in_valid5 = 1'b1;
      lat = 0;
      do begin
         tick();
         in_valid5 = 1'b0;
         lat++;
      end while (!out_valid5 && lat < 8);
      n_vec++;
      if (lat !== 1 || {sum5, cout5, ovf5, zero5} !== {5'h1E, 1'b1, 1'b0, 1'b0})
         begin n_err++; $display("FAIL w5_31p31 got lat %0d %h want lat 1 %h", lat, {sum5, cout5, ovf5, zero5}, {5'h1E, 3'b100}); end
      tick();
      exp5_q.delete();
      for (int cyc = 0; cyc < 40 && got < 10; cyc++) begin
         a5 = 5'($urandom); b5 = 5'($urandom); cin5 = 1'($urandom); op5 = 1'($urandom);
         in_valid5 = (sent < 10);
         #1;
         if (out_valid5) begin
            obs = {3'b000, sum5, cout5, ovf5, zero5};
            n_vec++;
            if (exp5_q.size() == 0) begin n_err++; $display("FAIL w5_extra got %h want none", obs); end
            else if (obs !== exp5_q[0]) begin n_err++; $display("FAIL w5_result got %h want %h", obs, exp5_q[0]); end
            if (exp5_q.size() != 0) void'(exp5_q.pop_front());
            got++;
         end
         if (in_valid5 && in_ready5) begin exp5_q.push_back(ref_calc(5, {3'b000, a5}, {3'b000, b5}, cin5, op5)); sent++; end
         tick();
      end
      in_valid5 = 1'b0;
      n_vec++;
      if (got !== 10) begin n_err++; $display("FAIL w5_count got %0d want 10", got); end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_corners();
      test_stream();
      test_backpressure();
      test_random_flow();
      test_mid_reset();
      test_w5();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1);
   end

endmodule
